pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the 5-stage CPU. Replaces the hand-written
//  per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one elastic block.
//  Adds a valid/ready handshake, an optional 2-entry skid buffer and a flush-bubble counter.
//  Keeps the CU stall/flush semantics. Instantiated once per stage boundary.
// PARAMETERS
//  CTRL_W              16  control-field width; zeroed on flush/bubble (0 = NOP)
//  DATA_W              96  datapath-field width (pc, alu result, rt data, ...)
//  SKID                1   1 = two-entry skid buffer; 0 = single register entry
//  CLEAR_DATA_ON_FLUSH 1   1 = data zeroed on flush; 0 = data held on flush
//  CNT_W               16  width of bubble_cnt
// PORTS
//  clk        in   1       stage clock; all state updates on FALLING edge
//  reset_n    in   1       asynchronous, active-low reset
//  stall      in   1       CU stall: freeze all state
//  flush      in   1       CU flush: kill stage contents (ignored while stall=1)
//  in_valid   in   1       upstream beat valid
//  in_ready   out  1       stage can accept a beat this edge (combinational)
//  in_ctrl    in   CTRL_W  upstream control fields
//  in_data    in   DATA_W  upstream datapath fields
//  out_valid  out  1       output entry valid (registered)
//  out_ready  in   1       downstream accepts the output entry
//  out_ctrl   out  CTRL_W  output control fields; 0 whenever out_valid=0
//  out_data   out  DATA_W  output datapath fields
//  occupancy  out  2       entries held: 0..2 (max 1 when SKID=0)
//  bubble_cnt out  CNT_W   count of edges on which flush killed >=1 valid entry; saturating
// BEHAVIOUR
//  - Reset (reset_n=0, async): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, bubble_cnt=0,
//    skid entry invalid and zeroed. in_ready=0 while reset_n=0.
//  - Accept = in_valid & in_ready. Release = out_valid & out_ready. Both sampled at the falling edge.
//  - Priority at each falling edge: reset_n > stall > flush > normal.
//  - stall=1: no state changes. in_ready=0. flush is ignored, so the CU holds flush until stall drops.
//  - flush=1 & stall=0: all entries invalidated. ctrl is zeroed.
//    data is zeroed if CLEAR_DATA_ON_FLUSH, else held. in_ready=0, so no beat is taken on that edge.
//    bubble_cnt+1 if any entry was valid; it stops at 2^CNT_W-1.
//  - SKID=0: in_ready = reset_n & !stall & !flush & (!out_valid | out_ready).
//    Accept loads the entry (1-edge latency). Release without accept sets out_valid=0 and out_ctrl=0.
//  - SKID=1: states EMPTY(0), ONE(1), FULL(2). Main entry drives the outputs.
//    in_ready = reset_n & !stall & !flush & (state!=FULL).
//      EMPTY: accept -> ONE (beat into main).
//      ONE: accept & release -> ONE (beat replaces main); accept only -> FULL (beat into skid);
//           release only -> EMPTY (main ctrl zeroed).
//      FULL: release -> ONE (skid moves to main, skid cleared). in_ready=0, so no accept.
//    Order is strictly FIFO. No beat is dropped or duplicated.
//  - Latency is one falling edge from accept to out_valid when empty. Throughput is 1 beat/edge.
//  - occupancy = state. With SKID=0 it is 0 or 1.
//  - Reset asserted mid-operation discards all entries immediately. bubble_cnt is not incremented.
// TESTING
//  1 reset: reset_n=0 mid-stream with 2 entries held -> outputs 0 at once, occupancy=0, in_ready=0.
//  2 stream: SKID=1, out_ready=1, in_data=1..8 on 8 edges -> out_data 1..8 one edge later, occupancy=1.
//  3 backpressure: out_ready=0, push 0xA,0xB,0xC -> occupancy 2, in_ready=0, 0xC held upstream;
//    set out_ready=1 -> outputs 0xA,0xB,0xC in order.
//  4 stall+flush: stall=1,flush=1 for 3 edges -> nothing changes, bubble_cnt unchanged;
//    drop stall -> entries killed, out_ctrl=0, bubble_cnt=1.
//  5 flush empty: flush with occupancy=0 -> bubble_cnt unchanged.
//    CLEAR_DATA_ON_FLUSH=0 -> out_data keeps its last value, out_valid=0.
//  6 SKID=0: out_ready=0 with entry held -> in_ready=0; out_ready=1 & in_valid=1 -> new beat on same edge.
//    CNT_W=2: 5 flushes -> bubble_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic inter-stage pipeline register for the 5-stage CPU.
// Carries a control field (zeroed on bubble/flush, 0 = NOP) and a datapath
// field across one stage boundary. It has a valid/ready handshake, an optional
// 2-entry skid buffer, and a saturating count of flush-generated bubbles.
// All state updates on the FALLING edge of clk. The reset is asynchronous and
// active low.
//
// Ports
//   clk, reset_n          stage clock (falling edge), async active-low reset
//   stall, flush          CU controls; stall has priority over flush
//   in_valid/in_ready     upstream handshake (in_ready is combinational)
//   in_ctrl, in_data      upstream beat
//   out_valid/out_ready   downstream handshake (out_valid is registered)
//   out_ctrl, out_data    main entry contents; out_ctrl is 0 when out_valid=0
//   occupancy             entries held (0..2, at most 1 when SKID=0)
//   bubble_cnt            edges on which a flush killed >=1 valid entry
module pipe_stage_reg #(
  parameter int CTRL_W              = 16,
  parameter int DATA_W              = 96,
  parameter int SKID                = 1,
  parameter int CLEAR_DATA_ON_FLUSH = 1,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              vld;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           st, st_n;
  entry_t           main_q, main_n;   // drives the outputs
  entry_t           skid_q, skid_n;   // second entry, only used when SKID=1
  entry_t           beat;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             room, acc, rel;

  // With a skid entry, readiness depends only on our own fill level, which
  // breaks the combinational out_ready -> in_ready path. Without one, the
  // single entry can be refilled on the same edge it drains.
  assign room     = (SKID != 0) ? (st != FULL) : (!main_q.vld || out_ready);
  assign in_ready = reset_n && !stall && !flush && room;
  assign acc      = in_valid && in_ready;
  assign rel      = main_q.vld && out_ready;
  assign beat     = {1'b1, in_ctrl, in_data};

  always_comb begin
    st_n   = st;
    main_n = main_q;
    skid_n = skid_q;
    cnt_n  = cnt_q;
    if (stall) begin
      // freeze everything; a pending flush waits for stall to drop
    end else if (flush) begin
      if ((main_q.vld || skid_q.vld) && (cnt_q != '1))
        cnt_n = cnt_q + 1'b1;
      main_n.vld  = 1'b0;
      main_n.ctrl = '0;
      skid_n.vld  = 1'b0;
      skid_n.ctrl = '0;
      if (CLEAR_DATA_ON_FLUSH != 0) begin
        main_n.data = '0;
        skid_n.data = '0;
      end
      st_n = EMPTY;
    end else if (SKID != 0) begin
      case (st)
        EMPTY: if (acc) begin
          main_n = beat;
          st_n   = ONE;
        end
        ONE: begin
          if (acc && rel) begin
            main_n = beat;
          end else if (acc) begin
            skid_n = beat;
            st_n   = FULL;
          end else if (rel) begin
            // data is left in place; only the NOP marking matters
            main_n.vld  = 1'b0;
            main_n.ctrl = '0;
            st_n        = EMPTY;
          end
        end
        FULL: if (rel) begin
          main_n = skid_q;
          skid_n = '0;
          st_n   = ONE;
        end
        default: st_n = EMPTY;
      endcase
    end else begin
      if (acc) begin
        main_n = beat;
        st_n   = ONE;
      end else if (rel) begin
        main_n.vld  = 1'b0;
        main_n.ctrl = '0;
        st_n        = EMPTY;
      end
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      st     <= st_n;
      main_q <= main_n;
      skid_q <= skid_n;
      cnt_q  <= cnt_n;
    end
  end

  assign out_valid  = main_q.vld;
  assign out_ctrl   = main_q.ctrl;
  assign out_data   = main_q.data;
  assign occupancy  = st;
  assign bubble_cnt = cnt_q;

endmodule
